// File: rtl/mem_trace_pkg.sv
// Shared types for the data-bus tracer (state enum, trace entry, widths).
// Optional feature macro: TRACE_TIMESTAMP_EN adds a per-entry timestamp.
package mem_trace_pkg;

  localparam int OVF_W    = 16;
  localparam int POST_W   = 16;
  localparam int ENT_PC_W = 32;
  localparam int ENT_AD_W = 32;
  localparam int ENT_DW   = 32;
  localparam int ENT_TS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  // Fields are sized for the widest supported build; narrower builds zero-extend.
  typedef struct packed {
    logic [ENT_PC_W-1:0] pc;
    logic [ENT_AD_W-1:0] adr;
    logic [ENT_DW-1:0]   data;
    logic                we;
`ifdef TRACE_TIMESTAMP_EN
    logic [ENT_TS_W-1:0] ts;
`endif
  } trace_entry_t;

  function automatic logic [OVF_W-1:0] sat_inc(
    input logic [OVF_W-1:0] v
  );
    return (&v) ? v : v + OVF_W'(1);
  endfunction

endpackage

// File: rtl/trace_ring_ram.sv
// Circular entry store with FWFT head, push/pop and overwrite-on-full.
// Optional feature macro: TRACE_TIMESTAMP_EN (carried inside trace_entry_t).
module trace_ring_ram
  import mem_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               wrap_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  trace_entry_t       wdata_i,
  output trace_entry_t       head_o,
  output logic               valid_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               lost_o
);

  localparam int PTR_W = $clog2(DEPTH);

  trace_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pop, full, grow, wr_en, adv_rd;

  always_comb begin
    pop    = pop_i && (cnt_q != '0);
    full   = (cnt_q == CNT_W'(DEPTH));
    grow   = push_i && (!full || pop);
    wr_en  = grow || (push_i && full && wrap_i);
    // A wrapping write lands on the oldest slot, so the head must move too.
    adv_rd = pop || (push_i && full && !pop && wrap_i);
    lost_o = push_i && full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (adv_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (grow && !pop) cnt_d = cnt_q + CNT_W'(1);
    if (!grow && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign valid_o = (cnt_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/mem_trace_buffer.sv
// Data-memory bus tracer: qualifier, trigger FSM, counters around the ring.
// Optional feature macro: TRACE_TIMESTAMP_EN (cycle timestamp on rd_ts).
module mem_trace_buffer
  import mem_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [PC_W-1:0]            mon_pc,
  input  logic                       mon_memwrite,
  input  logic                       mon_memread,
  input  logic [ADDR_W-1:0]          mon_adr,
  input  logic [DATA_W-1:0]          mon_wdata,
  input  logic [DATA_W-1:0]          mon_rdata,
  input  logic [ADDR_W-1:0]          cfg_lo,
  input  logic [ADDR_W-1:0]          cfg_hi,
  input  logic                       cfg_rd_en,
  input  logic                       cfg_wrap,
  input  logic                       cfg_trig_any,
  input  logic [ADDR_W-1:0]          cfg_trig_adr,
  input  logic [POST_W-1:0]          cfg_post,
  input  logic                       arm,
  input  logic                       stop,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [PC_W-1:0]            rd_pc,
  output logic [ADDR_W-1:0]          rd_adr,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_we,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]            rd_ts,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [OVF_W-1:0]           ovf_cnt,
  output logic [1:0]                 state_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  if (PC_W > ENT_PC_W || ADDR_W > ENT_AD_W || DATA_W > ENT_DW ||
      TS_W > ENT_TS_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
  begin : g_cfg_chk
    $error("mem_trace_buffer: unsupported parameter set");
  end

  trace_state_e      state_q, state_d;
  logic [POST_W-1:0] cap_q, cap_d, cap_inc;
  logic [OVF_W-1:0]  ovf_q, ovf_d;

  logic in_win, is_ev, qualify, trig_hit, post_hit;
  logic push, clear, lost, head_valid;
  trace_entry_t wr_entry, head;

  always_comb begin
    in_win   = (mon_adr >= cfg_lo) && (mon_adr <= cfg_hi);
    is_ev    = mon_memwrite || (cfg_rd_en && mon_memread);
    qualify  = enable && is_ev && in_win;
    trig_hit = qualify && (cfg_trig_any || mon_adr == cfg_trig_adr);
    cap_inc  = cap_q + POST_W'(1);
    post_hit = (cfg_post != '0) && (cap_inc == cfg_post);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm && !stop) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (stop)          state_d = ST_DONE;
        else if (trig_hit) state_d = post_hit ? ST_DONE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (stop)                     state_d = ST_DONE;
        else if (qualify && post_hit) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // stop takes priority: it suppresses both re-arm and the same-cycle capture.
  always_comb begin
    clear = 1'b0;
    push  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: clear = arm && !stop;
      ST_ARMED:         push  = trig_hit && !stop;
      ST_CAPTURE:       push  = qualify && !stop;
      default: ;
    endcase
  end

  assign state_o = state_q;

  always_comb begin
    cap_d = cap_q;
    ovf_d = ovf_q;
    if (clear) begin
      cap_d = '0;
      ovf_d = '0;
    end else begin
      if (push) cap_d = cap_inc;
      if (lost) ovf_d = sat_inc(ovf_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= '0;
      ovf_q <= '0;
    end else begin
      cap_q <= cap_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q;
    if (clear)       ts_d = '0;
    else if (enable) ts_d = ts_q + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end
`endif

  always_comb begin
    wr_entry      = '0;
    wr_entry.pc   = ENT_PC_W'(mon_pc);
    wr_entry.adr  = ENT_AD_W'(mon_adr);
    wr_entry.data = ENT_DW'(mon_memwrite ? mon_wdata : mon_rdata);
    wr_entry.we   = mon_memwrite;
`ifdef TRACE_TIMESTAMP_EN
    wr_entry.ts   = ENT_TS_W'(ts_q);
`endif
  end

  trace_ring_ram #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear),
    .wrap_i  (cfg_wrap),
    .push_i  (push),
    .pop_i   (rd_ready),
    .wdata_i (wr_entry),
    .head_o  (head),
    .valid_o (head_valid),
    .count_o (count),
    .lost_o  (lost)
  );

  assign rd_valid = head_valid;
  assign rd_pc    = head.pc[PC_W-1:0];
  assign rd_adr   = head.adr[ADDR_W-1:0];
  assign rd_data  = head.data[DATA_W-1:0];
  assign rd_we    = head.we;
`ifdef TRACE_TIMESTAMP_EN
  assign rd_ts    = head.ts[TS_W-1:0];
`endif
  assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_mem_trace_buffer.sv
// Bench for mem_trace_buffer: directed cases plus random traffic vs a queue model.
// Optional feature macro: TRACE_TIMESTAMP_EN also checks rd_ts.
module tb_mem_trace_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int S_IDLE = 0, S_ARMED = 1, S_CAPT = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        reset, enable, mon_memwrite, mon_memread;
  logic        cfg_rd_en, cfg_wrap, cfg_trig_any, arm, stop, rd_ready;
  logic [31:0] mon_pc, mon_adr, mon_wdata, mon_rdata;
  logic [31:0] cfg_lo, cfg_hi, cfg_trig_adr;
  logic [15:0] cfg_post;
  logic        rd_valid, rd_we;
  logic [31:0] rd_pc, rd_adr, rd_data;
  logic [CW-1:0] count;
  logic [15:0] ovf_cnt;
  logic [1:0]  state_o;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] rd_ts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc, adr, data, ts;
    logic        we;
  } ent_t;

  ent_t        mq[$];
  int          m_state = S_IDLE;
  int          m_ovf   = 0;
  int          m_cap   = 0;
  logic [31:0] m_ts    = '0;

  always #5 clk = ~clk;

  mem_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mon_pc       (mon_pc),
    .mon_memwrite (mon_memwrite),
    .mon_memread  (mon_memread),
    .mon_adr      (mon_adr),
    .mon_wdata    (mon_wdata),
    .mon_rdata    (mon_rdata),
    .cfg_lo       (cfg_lo),
    .cfg_hi       (cfg_hi),
    .cfg_rd_en    (cfg_rd_en),
    .cfg_wrap     (cfg_wrap),
    .cfg_trig_any (cfg_trig_any),
    .cfg_trig_adr (cfg_trig_adr),
    .cfg_post     (cfg_post),
    .arm          (arm),
    .stop         (stop),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_pc        (rd_pc),
    .rd_adr       (rd_adr),
    .rd_data      (rd_data),
    .rd_we        (rd_we),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts        (rd_ts),
`endif
    .count        (count),
    .ovf_cnt      (ovf_cnt),
    .state_o      (state_o)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: what the tracer should hold after the coming edge.
  task automatic model_edge();
    bit   qual, trig, pop, clr, psh;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_state = S_IDLE;
      m_ovf = 0;
      m_cap = 0;
      m_ts = '0;
      return;
    end
    qual = enable && (mon_memwrite || (cfg_rd_en && mon_memread)) &&
           mon_adr >= cfg_lo && mon_adr <= cfg_hi;
    trig = qual && (cfg_trig_any || mon_adr == cfg_trig_adr);
    pop  = rd_ready && mq.size() > 0;
    clr  = (m_state == S_IDLE || m_state == S_DONE) && arm && !stop;
    psh  = !stop && ((m_state == S_ARMED && trig) ||
                     (m_state == S_CAPT && qual));
    e = '{pc: mon_pc, adr: mon_adr, ts: m_ts, we: mon_memwrite,
          data: mon_memwrite ? mon_wdata : mon_rdata};
    if (clr) begin
      mq.delete();
      m_ovf = 0;
      m_cap = 0;
      m_ts = '0;
      m_state = S_ARMED;
      return;
    end
    if (enable) m_ts++;
    if (pop) void'(mq.pop_front());
    if (psh) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else begin
        if (cfg_wrap) begin
          void'(mq.pop_front());
          mq.push_back(e);
        end
        if (m_ovf < 65535) m_ovf++;
      end
      m_cap++;
      if (cfg_post != 0 && m_cap == int'(cfg_post)) m_state = S_DONE;
      else if (m_state == S_ARMED) m_state = S_CAPT;
    end
    if (stop && (m_state == S_ARMED || m_state == S_CAPT)) m_state = S_DONE;
  endtask

  task automatic compare_all();
    ent_t h;
    bit   v;
    v = mq.size() > 0;
    h = v ? mq[0] : '{default: '0};
    check("state", state_o, m_state);
    check("count", count, mq.size());
    check("ovf_cnt", ovf_cnt, m_ovf);
    check("rd_valid", rd_valid, v);
    check("rd_pc", rd_pc, h.pc);
    check("rd_adr", rd_adr, h.adr);
    check("rd_data", rd_data, h.data);
    check("rd_we", rd_we, h.we);
`ifdef TRACE_TIMESTAMP_EN
    check("rd_ts", rd_ts, h.ts);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_store(logic [31:0] a, logic [31:0] d);
    mon_memwrite = 1'b1;
    mon_adr = a;
    mon_wdata = d;
    mon_rdata = $urandom;
    mon_pc = $urandom;
    step();
    mon_memwrite = 1'b0;
  endtask

  task automatic rearm();
    stop = 1'b1;
    step();
    stop = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    mon_memwrite = 1'b0; mon_memread = 1'b0;
    mon_pc = '0; mon_adr = '0; mon_wdata = '0; mon_rdata = '0;
    cfg_lo = 32'h0; cfg_hi = 32'hFFFF_FFFF; cfg_rd_en = 1'b0;
    cfg_wrap = 1'b0; cfg_trig_any = 1'b1; cfg_trig_adr = '0;
    cfg_post = 16'd0; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_state", state_o, 0);
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_ovf", ovf_cnt, 0);

    // 1: three stores, captured in order
    rearm();
    do_store(32'h10, 32'd7);
    do_store(32'h14, 32'd8);
    do_store(32'h18, 32'd9);
    check("t1_count", count, 3);
    check("t1_adr0", rd_adr, 32'h10);
    check("t1_data0", rd_data, 32'd7);
    check("t1_we", rd_we, 1);
    pop_one();
    check("t1_data1", rd_data, 32'd8);
    pop_one();
    check("t1_data2", rd_data, 32'd9);

    // 2: address window edges
    cfg_lo = 32'h100; cfg_hi = 32'h1FF;
    rearm();
    do_store(32'h0FC, 32'd1);
    do_store(32'h100, 32'd2);
    do_store(32'h1FF, 32'd3);
    do_store(32'h200, 32'd4);
    check("t2_count", count, 2);
    check("t2_adr0", rd_adr, 32'h100);
    pop_one();
    check("t2_adr1", rd_adr, 32'h1FF);
    cfg_lo = 32'h0; cfg_hi = 32'hFFFF_FFFF;

    // 3: overflow, drop-newest then overwrite-oldest
    for (int w = 0; w < 2; w++) begin
      cfg_wrap = w[0];
      rearm();
      for (int i = 0; i < 6; i++) do_store(32'h300 + 4 * i, i);
      check("t3_count", count, 4);
      check("t3_ovf", ovf_cnt, 2);
      check("t3_head", rd_adr, w ? 32'h308 : 32'h300);
    end
    cfg_wrap = 1'b0;

    // 4: address trigger with post count
    cfg_trig_any = 1'b0; cfg_trig_adr = 32'h40; cfg_post = 16'd3;
    rearm();
    do_store(32'h20, 32'd1);
    check("t4_armed", state_o, S_ARMED);
    do_store(32'h40, 32'd2);
    do_store(32'h44, 32'd3);
    do_store(32'h48, 32'd4);
    do_store(32'h4C, 32'd5);
    check("t4_count", count, 3);
    check("t4_state", state_o, S_DONE);
    check("t4_head", rd_adr, 32'h40);
    cfg_trig_any = 1'b1; cfg_post = 16'd0;

    // 5: full buffer, push and pop together
    rearm();
    for (int i = 0; i < 4; i++) do_store(32'h500 + 4 * i, i);
    rd_ready = 1'b1;
    do_store(32'h510, 32'd4);
    rd_ready = 1'b0;
    check("t5_count", count, 4);
    check("t5_ovf", ovf_cnt, 0);
    check("t5_head", rd_adr, 32'h504);

    // 6: reset in the middle of a capture
    rearm();
    for (int i = 0; i < 3; i++) do_store(32'h600 + 4 * i, i);
    check("t6_capt", state_o, S_CAPT);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_valid", rd_valid, 0);
    check("t6_count", count, 0);
    check("t6_state", state_o, S_IDLE);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        cfg_lo = $urandom_range(0, 32);
        cfg_hi = $urandom_range(16, 80);
        cfg_rd_en = 1'($urandom % 2);
        cfg_wrap = 1'($urandom % 2);
        cfg_trig_any = 1'($urandom % 2);
        cfg_trig_adr = 4 * $urandom_range(0, 15);
        cfg_post = 16'($urandom_range(0, 5));
      end
      enable = ($urandom % 8) != 0;
      mon_memwrite = 1'($urandom % 2);
      mon_memread = 1'($urandom % 2);
      mon_adr = 4 * $urandom_range(0, 20);
      mon_wdata = $urandom;
      mon_rdata = $urandom;
      mon_pc = $urandom;
      arm = ($urandom % 16) == 0;
      stop = ($urandom % 32) == 0;
      reset = ($urandom % 300) == 0;
      rd_ready = ($urandom % 3) == 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
